// File: rtl/fnd_display_arbiter.sv
// fnd_display_arbiter: shares a 4-digit common-anode FND between two requesters.
// Round-robin grant with minimum hold, per-frame snapshot, serial BCD, scan drive.
module fnd_display_arbiter #(
   parameter int TICK_DIV   = 100000,
   parameter int BLANK_CYC  = 1000,
   parameter int HOLD_TICKS = 2000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  req,
   input  logic [13:0] val0,
   input  logic [13:0] val1,
   output logic [1:0]  grant,
   output logic [3:0]  fnd_digit,
   output logic [7:0]  fnd_data
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int HW = $clog2(HOLD_TICKS + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [TW-1:0] BLANK_END = TW'(BLANK_CYC);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_TICKS);

   // one-hot owner encoding doubles as the grant vector
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OWN0 = 2'b01,
      OWN1 = 2'b10
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic [TW-1:0]   tick_cnt;
   logic            tick;
   logic            blank;
   logic [1:0]      digit_sel;
   logic [HW-1:0]   hold_cnt;
   logic            hold_zero;
   logic            last_served;
   logic [13:0]     snap;
   logic [13:0]     src;
   logic [29:0]     dd;
   logic [3:0]      dd_cnt;
   logic            busy;
   logic            snap_go;
   logic [15:0]     bcd;
   logic            ovf;
   logic [3:0]      nib;
   logic            zero3;
   logic            zero2;
   logic            zero1;
   logic            suppress;
   logic [3:0]      digit_nx;
   logic [7:0]      data_nx;

   function automatic logic [7:0] seg7(input logic [3:0] n);
      logic [7:0] s;
      case (n)
         4'd0:    s = 8'hC0;
         4'd1:    s = 8'hF9;
         4'd2:    s = 8'hA4;
         4'd3:    s = 8'hB0;
         4'd4:    s = 8'h99;
         4'd5:    s = 8'h92;
         4'd6:    s = 8'h82;
         4'd7:    s = 8'hF8;
         4'd8:    s = 8'h80;
         4'd9:    s = 8'h90;
         default: s = 8'hFF;
      endcase
      return s;
   endfunction

   // one double-dabble step: add 3 to each BCD nibble >= 5, then shift left
   function automatic logic [29:0] dabble(input logic [29:0] d);
      logic [29:0] t;
      t = d;
      for (int k = 0; k < 4; k++) begin
         if (t[14+4*k +: 4] >= 4'd5)
            t[14+4*k +: 4] = t[14+4*k +: 4] + 4'd3;
      end
      return {t[28:0], 1'b0};
   endfunction

   assign tick      = (tick_cnt == TICK_LAST);
   assign blank     = (tick_cnt < BLANK_END);
   assign hold_zero = (hold_cnt == '0);
   assign src       = (state == OWN1) ? val1 : val0;
   assign snap_go   = tick && (digit_sel == 2'd3) && (state != IDLE) && !busy;

   // free-running digit tick divider
   always_ff @(posedge clk or posedge reset) begin
      if (reset)     tick_cnt <= '0;
      else if (tick) tick_cnt <= '0;
      else           tick_cnt <= tick_cnt + 1'b1;
   end

   // scan position advances once per tick
   always_ff @(posedge clk or posedge reset) begin
      if (reset)     digit_sel <= 2'd0;
      else if (tick) digit_sel <= digit_sel + 2'd1;
   end

   // arbiter state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // arbiter next-state: owner drop or expired hold hands over
   always_comb begin
      state_nx = state;
      unique case (1'b1)
         (state == OWN0): begin
            if (!req[0])                state_nx = req[1] ? OWN1 : IDLE;
            else if (hold_zero && req[1]) state_nx = OWN1;
         end
         (state == OWN1): begin
            if (!req[1])                state_nx = req[0] ? OWN0 : IDLE;
            else if (hold_zero && req[0]) state_nx = OWN0;
         end
         default: begin
            if (req == 2'b11)  state_nx = last_served ? OWN0 : OWN1;
            else if (req[0])   state_nx = OWN0;
            else if (req[1])   state_nx = OWN1;
            else               state_nx = IDLE;
         end
      endcase
   end

   // arbiter outputs: grant is a straight decode of the owner flops
   always_comb begin
      grant = state;
   end

   // hold timer and round-robin memory, reloaded on every new ownership
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_cnt    <= '0;
         last_served <= 1'b1;
      end else if (state_nx != state && state_nx != IDLE) begin
         hold_cnt    <= HOLD_LOAD;
         last_served <= (state_nx == OWN1);
      end else if (tick && state != IDLE && !hold_zero) begin
         hold_cnt    <= hold_cnt - 1'b1;
      end
   end

   // frame snapshot and serial binary-to-BCD conversion
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         snap   <= '0;
         dd     <= '0;
         dd_cnt <= '0;
         busy   <= 1'b0;
         bcd    <= '0;
         ovf    <= 1'b0;
      end else if (state_nx == IDLE) begin
         dd_cnt <= '0;
         busy   <= 1'b0;
         bcd    <= '0;
         ovf    <= 1'b0;
      end else if (busy) begin
         if (dd_cnt == 4'd14) begin
            bcd  <= dd[29:14];
            ovf  <= (snap > 14'd9999);
            busy <= 1'b0;
         end else begin
            dd     <= dabble(dd);
            dd_cnt <= dd_cnt + 4'd1;
         end
      end else if (snap_go) begin
         snap   <= src;
         dd     <= {16'd0, src};
         dd_cnt <= '0;
         busy   <= 1'b1;
      end
   end

   // digit value, leading-zero suppression and pin images
   always_comb begin
      nib      = bcd[3:0];
      zero3    = (bcd[15:12] == 4'd0);
      zero2    = zero3 && (bcd[11:8] == 4'd0);
      zero1    = zero2 && (bcd[7:4] == 4'd0);
      suppress = 1'b0;
      case (digit_sel)
         2'd1: begin nib = bcd[7:4];   suppress = zero1; end
         2'd2: begin nib = bcd[11:8];  suppress = zero2; end
         2'd3: begin nib = bcd[15:12]; suppress = zero3; end
         default: begin nib = bcd[3:0]; suppress = 1'b0; end
      endcase
      digit_nx = 4'b1111;
      if (state != IDLE && !blank)
         digit_nx = ~(4'b0001 << digit_sel);
      data_nx = 8'hFF;
      if (state == IDLE)  data_nx = 8'hFF;
      else if (ovf)       data_nx = 8'hBF;
      else if (suppress)  data_nx = 8'hFF;
      else                data_nx = seg7(nib);
   end

   // registered pin drive
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fnd_digit <= 4'b1111;
         fnd_data  <= 8'hFF;
      end else begin
         fnd_digit <= digit_nx;
         fnd_data  <= data_nx;
      end
   end

endmodule
